// File: rtl/alu_rf_issue_ctrl.sv
// alu_rf_issue_ctrl: queues R-type ops and issues them onto the shared RF/ALUControl/ALU datapath, stalling on RAW hazards; optional STALL_CNT_EN adds stall_cnt.
// Latency: an op is driven on rs1/rs2/ALUop/func >= 2 cycles after enqueue; its rd/we/wb_valid appear 2 cycles after it is driven.
// Backpressure: in_ready drops when the FIFO is full or a drain is requested/active; the FIFO head waits while it reads an unwritten rd.
module alu_rf_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_func,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [1:0]       ALUop,
  output logic [5:0]       func,
  output logic [4:0]       rd,
  output logic             we,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             wb_valid,
  output logic             busy
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0] aluop;
    logic [5:0] func;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
  } op_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
  } stg_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

  // Reject configurations the pointer arithmetic cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_cfg_chk
    $error("alu_rf_issue_ctrl: FIFO_DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  op_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  op_t           in_op;
  op_t           head;
  // iss_stg: op currently driven to the RF; ex_stg: its ALU cycle; wb_stg: its write slot.
  stg_t          iss_stg;
  stg_t          ex_stg;
  stg_t          wb_stg;
  state_t        state;
  logic          push;
  logic          pop;
  logic          hazard;
  logic          quiet_nxt;

  // True when stage s will write a register that op o reads.
  function automatic logic src_pending(input stg_t s, input op_t o);
    return s.vld && s.we && ((o.rs1 == s.rd) || (o.rs2 == s.rd));
  endfunction

  assign in_op = {in_aluop, in_func, in_rs1, in_rs2, in_rd, in_we};
  assign head  = mem[rd_ptr];

  // The head would be read next cycle; producers driven this cycle (iss) or
  // last cycle (ex) have not been written yet, and there is no bypass.
  assign hazard    = (cnt != '0) && (src_pending(iss_stg, head) || src_pending(ex_stg, head));
  assign pop       = (cnt != '0) && !hazard;
  assign in_ready  = (cnt != DEPTH_C) && !drain_req && (state != DRAIN);
  assign push      = in_valid && in_ready;
  assign cnt_nxt   = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign quiet_nxt = (cnt_nxt == '0) && !pop && !iss_stg.vld && !ex_stg.vld;

  assign busy     = (cnt != '0) || iss_stg.vld || ex_stg.vld || wb_stg.vld;
  assign wb_valid = wb_stg.vld;
  assign we       = wb_stg.vld && wb_stg.we;
  assign rd       = wb_stg.rd;

  // Op storage; contents need no reset because cnt gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_op;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
    end
  end

  // Issue registers and shadow pipeline; stalls put a bubble into iss_stg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1     <= '0;
      rs2     <= '0;
      ALUop   <= '0;
      func    <= '0;
      iss_stg <= '0;
      ex_stg  <= '0;
      wb_stg  <= '0;
    end else begin
      if (pop) begin
        rs1   <= head.rs1;
        rs2   <= head.rs2;
        ALUop <= head.aluop;
        func  <= head.func;
      end
      iss_stg <= pop ? '{vld: 1'b1, rd: head.rd, we: head.we} : '0;
      ex_stg  <= iss_stg;
      wb_stg  <= ex_stg;
    end
  end

  // Control FSM; drain request takes priority from every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= drain_req && quiet_nxt;
      if (drain_req)            state <= DRAIN;
      else if (state == DRAIN)  state <= IDLE;
      else if (hazard)          state <= STALL;
      else if (quiet_nxt)       state <= IDLE;
      else                      state <= RUN;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of STALL cycles, restarted when a drain completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (drain_req && quiet_nxt && !drain_done) begin
      stall_cnt <= '0;
    end else if ((state == STALL) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_rf_issue_ctrl.sv
// tb_alu_rf_issue_ctrl: drives directed and random op streams into alu_rf_issue_ctrl.
// Expected outputs come from a cycle-numbered model: an op driven in cycle d writes at d+2,
// and a reader of that register may be driven no earlier than cycle d+3.
module tb_alu_rf_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_aluop = '0;
  logic [5:0] in_func = '0;
  logic [4:0] in_rs1 = '0;
  logic [4:0] in_rs2 = '0;
  logic [4:0] in_rd = '0;
  logic       in_we = 1'b0;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [1:0] ALUop;
  logic [5:0] func;
  logic [4:0] rd;
  logic       we;
  logic       drain_req = 1'b0;
  logic       drain_done;
  logic       wb_valid;
  logic       busy;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_rf_issue_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .rs1        (rs1),
    .rs2        (rs2),
    .ALUop      (ALUop),
    .func       (func),
    .rd         (rd),
    .we         (we),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .wb_valid   (wb_valid),
    .busy       (busy)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] aluop;
    logic [5:0] func;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
  } op_t;

  typedef struct {
    int  d;
    op_t op;
  } fl_t;

  // Reference model state
  op_t  q[$];
  fl_t  fl[$];
  int   reg_free[32];
  int   cyc;
  op_t  last_iss;
  logic drain_prev;
  logic in_stall;
  int   exp_stall;

  int vec;
  int errs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic [1:0] a, input logic [5:0] f, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] d, input logic w);
    op_t o;
    o = {a, f, s1, s2, d, w};
    return o;
  endfunction

  task automatic model_clear();
    q.delete();
    fl.delete();
    for (int r = 0; r < 32; r++) reg_free[r] = 0;
    last_iss   = '0;
    drain_prev = 1'b0;
    in_stall   = 1'b0;
    exp_stall  = 0;
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    in_valid  = 1'b0;
    drain_req = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_clear();
    chk("rst_we", we, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_rs1", rs1, 5'd0);
    chk("rst_rs2", rs2, 5'd0);
    chk("rst_rd", rd, 5'd0);
    chk("rst_ALUop", ALUop, 2'b00);
    chk("rst_func", func, 6'b000000);
`ifdef STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs, then advance the model across the edge.
  task automatic step(input logic v, input op_t o, input logic dreq);
    op_t  h;
    op_t  wop;
    logic wbv;
    logic ebusy;
    logic erdy;
    logic edone;
    logic blk;
    logic iss;
    logic bnext;
    @(negedge clk);
    in_valid  = v;
    in_aluop  = o.aluop;
    in_func   = o.func;
    in_rs1    = o.rs1;
    in_rs2    = o.rs2;
    in_rd     = o.rd;
    in_we     = o.we;
    drain_req = dreq;
    #1;
    while (fl.size() != 0 && fl[0].d < cyc - 2) void'(fl.pop_front());
    wbv = 1'b0;
    wop = '0;
    if (fl.size() != 0 && fl[0].d == cyc - 2) begin
      wbv = 1'b1;
      wop = fl[0].op;
    end
    ebusy = (q.size() != 0) || (fl.size() != 0);
    erdy  = (q.size() < DEPTH) && !dreq && !drain_prev;
    edone = drain_prev && !ebusy;
    chk("in_ready", in_ready, erdy);
    chk("busy", busy, ebusy);
    chk("wb_valid", wb_valid, wbv);
    chk("we", we, wbv && wop.we);
    if (wbv) chk("rd", rd, wop.rd);
    chk("rs1", rs1, last_iss.rs1);
    chk("rs2", rs2, last_iss.rs2);
    chk("ALUop", ALUop, last_iss.aluop);
    chk("func", func, last_iss.func);
    chk("drain_done", drain_done, edone);
`ifdef STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
    iss = 1'b0;
    blk = 1'b0;
    h   = '0;
    if (q.size() != 0) begin
      h   = q[0];
      blk = (reg_free[h.rs1] > cyc + 1) || (reg_free[h.rs2] > cyc + 1);
      iss = !blk;
    end
    if (in_stall) exp_stall++;
    in_stall = blk && !dreq && !drain_prev;
    if (iss) begin
      void'(q.pop_front());
      last_iss = h;
      fl.push_back('{d: cyc + 1, op: h});
      if (h.we) reg_free[h.rd] = cyc + 4;
    end
    if (v && erdy) q.push_back(o);
    bnext = (q.size() != 0) || (fl.size() != 0 && fl[fl.size()-1].d >= cyc - 1);
    if (dreq && !bnext && !edone) exp_stall = 0;
    drain_prev = dreq;
    cyc++;
  endtask

  task automatic idle(input int n, input logic dreq);
    for (int k = 0; k < n; k++) step(1'b0, '0, dreq);
  endtask

  initial begin
    op_t  o;
    logic dr;
    vec = 0;
    errs = 0;
    cyc = 0;
    model_clear();
    async_reset();

    // Independent add stream rd=rs1=rs2=i
    for (int i = 0; i < 4; i++) step(1'b1, mk(2'b10, 6'b100000, 5'(i), 5'(i), 5'(i), 1'b1), 1'b0);
    idle(6, 1'b0);

    // RAW: add r5, then sub reading r5
    step(1'b1, mk(2'b10, 6'b100000, 5'd5, 5'd5, 5'd5, 1'b1), 1'b0);
    step(1'b1, mk(2'b10, 6'b100010, 5'd31, 5'd5, 5'd6, 1'b1), 1'b0);
    idle(7, 1'b0);

    // FIFO full: dependent chain keeps the head stalled while pushes continue
    for (int i = 0; i < 10; i++) step(1'b1, mk(2'b10, 6'b100000, 5'(8 + i), 5'(8 + i), 5'(9 + i), 1'b1), 1'b0);
    idle(25, 1'b0);

    // Producer with we=0 creates no hazard
    step(1'b1, mk(2'b10, 6'b100100, 5'd1, 5'd2, 5'd7, 1'b0), 1'b0);
    step(1'b1, mk(2'b10, 6'b100101, 5'd7, 5'd7, 5'd8, 1'b1), 1'b0);
    idle(6, 1'b0);

    // Drain with three queued dependent ops
    step(1'b1, mk(2'b10, 6'b100000, 5'd3, 5'd3, 5'd20, 1'b1), 1'b0);
    step(1'b1, mk(2'b10, 6'b100000, 5'd20, 5'd3, 5'd21, 1'b1), 1'b0);
    step(1'b1, mk(2'b10, 6'b100000, 5'd21, 5'd3, 5'd22, 1'b1), 1'b0);
    step(1'b1, mk(2'b10, 6'b100000, 5'd4, 5'd4, 5'd23, 1'b1), 1'b1);
    idle(14, 1'b1);
    idle(3, 1'b0);

    // Drain request while idle
    idle(3, 1'b1);
    idle(2, 1'b0);

    // Async reset in the middle of a stall
    step(1'b1, mk(2'b10, 6'b100000, 5'd1, 5'd1, 5'd3, 1'b1), 1'b0);
    step(1'b1, mk(2'b10, 6'b100010, 5'd3, 5'd1, 5'd4, 1'b1), 1'b0);
    step(1'b0, '0, 1'b0);
    async_reset();
    idle(6, 1'b0);

    // Randomized traffic over a small register window, with occasional drain bursts
    dr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      o = mk(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) < 5) dr = !dr;
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, o, dr);
    end
    idle(10, 1'b1);
    idle(4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/alu_rf_issue_ctrl.md
Name: alu_rf_issue_ctrl

Overview:
- Issue controller that sequences R-type operations onto the shared RF + ALUControl + ALU datapath.
- Buffers incoming ops in a small FIFO and drives rs1/rs2, ALUop/func and the stage-aligned rd/we to the datapath.
- Stalls issue on read-after-write hazards against in-flight writes, and supports a drain request for quiescing before reconfiguration.

Parameters:
- FIFO_DEPTH, 4, op queue entries (power of two, >=2)
- CNT_W, 16, width of the optional stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op offered
- in_ready  out  1  FIFO can accept (not full and not draining)
- in_aluop  in  2  ALUop of offered op
- in_func  in  6  func field of offered op
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register
- in_we  in  1  op writes rd
- rs1  out  5  RF read address 1
- rs2  out  5  RF read address 2
- ALUop  out  2  to ALUControl
- func  out  6  to ALUControl
- rd  out  5  RF write address, aligned to result
- we  out  1  RF write enable, aligned to result
- drain_req  in  1  stop accepting, finish in-flight ops
- drain_done  out  1  level: drained and idle
- wb_valid  out  1  one-cycle pulse, an op completed writeback slot
- busy  out  1  FIFO non-empty or any op in flight

Behaviour:
- Datapath timing, fixed: RF read, ALUControl and ALU are each registered.
  - Op issued in cycle t (rs1/rs2/ALUop/func driven) gives A/B and ALU_Ctrl at t+1 and result at t+2.
  - rd/we for that op are driven in t+2 and written at the end of t+2.
- Pipeline tracking: two shadow stages, EX (t+1) and WB (t+2), each holding {valid, rd, we}. Both advance every cycle, never stall; a stall inserts a bubble into EX.
- Hazard: the FIFO head stalls if (head.rs1 or head.rs2) == X.rd with X.valid and X.we, for X in {EX, WB}.
  - No r0 special case; all 32 registers are tracked.
  - The RF has no write-through bypass, so a dependent op issues no earlier than t+3 after its producer.
- FSM states:
  - IDLE: FIFO empty and pipe empty. Go to RUN when the FIFO is non-empty.
  - RUN: issue the head each cycle if there is no hazard. Go to STALL on a hazard; go to DRAIN if drain_req; return to IDLE when empty.
  - STALL: no issue, bubble into EX. Return to RUN when the hazard clears (at most 2 cycles).
  - DRAIN: in_ready=0; keep issuing FIFO contents with normal hazard rules. When FIFO and pipe are empty, assert drain_done and hold it while drain_req=1. Go to IDLE when drain_req drops.
- Idle outputs: rs1/rs2/ALUop/func hold their last issued values; we=0 and wb_valid=0 in any cycle whose WB slot is empty or holds a bubble.
- FIFO behaviour:
  - Push on in_valid && in_ready.
  - Simultaneous push and pop on a full FIFO is not allowed: in_ready=0 when full, even if a pop occurs that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- wb_valid=1 in the cycle the WB slot holds a real op, regardless of its we.
- Reset (asynchronous, any time, including mid-drain or mid-stall):
  - FIFO empty; EX/WB invalid; state IDLE.
  - we=0, wb_valid=0, drain_done=0, busy=0, in_ready=1.
  - rs1=rs2=rd=0, ALUop=2'b00, func=6'b000000.
  - In-flight ops are discarded; no partial write is issued after rst_n rises.
- drain_req asserted while IDLE: enter DRAIN; drain_done=1 the next cycle.

Optional Feature:
- Macro STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [CNT_W-1:0], incremented each cycle in STALL and saturating at all-ones.
  - Reset to 0 by rst_n, and also cleared in the cycle drain_done first rises.
- When undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Independent stream: push add ops (ALUop=10, func=100000) rd=i, rs1=rs2=i for i=0..3. Expect issue on consecutive cycles with no STALL, and we=1, rd=0,1,2,3 on cycles t+2..t+5.
- RAW stall: push add rd=5 (rs1=rs2=5), then sub (func=100010) rs1=31, rs2=5, rd=6. Expect the second op issued exactly 3 cycles after the first, 2 STALL cycles, and stall_cnt=2 if enabled.
- FIFO full: hold the head stalled and push until in_ready=0 after FIFO_DEPTH entries. The push offered while full is not accepted; in_ready returns to 1 the cycle after a pop.
- we=0 producer: push op rd=7 with in_we=0, then an op reading r7. Expect no stall; wb_valid pulses with we=0.
- Drain: with 3 ops queued, assert drain_req. Expect in_ready=0 immediately, all 3 writebacks to occur, then drain_done=1, and a return to IDLE after drain_req deasserts.
- Async reset mid-STALL: assert rst_n=0 between edges. Expect we=0, busy=0 and in_ready=1 immediately, and no writeback pulse after release.
